// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// A round-robin grant picks a command in IDLE, the command is registered
// onto the ALU inputs (EXEC gives the ALU one cycle to settle), then the
// result is captured and held on a single response channel (RESP).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready may only rise for a requester whose req_valid is
// high. rsp_valid stays high, with rsp_* stable, until rsp_ready is seen.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_data,
  output logic [7:0]  rsp_flags,
  output logic [2:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_salida,
  input  logic [7:0]  alu_flags,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        prio;
  logic        grant;
  logic        accept;
  logic        rsp_hs;
  logic [2:0]  sel_opcode;
  logic [7:0]  sel_a;
  logic [7:0]  sel_b;
  logic [15:0] ops_cnt;

  assign ops_done = ops_cnt;

  // Round-robin grant: prio breaks ties, a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) begin
      grant = prio;
    end else if (req_valid[1]) begin
      grant = 1'b1;
    end
  end

  // Select the granted requester's command fields.
  always_comb begin
    sel_opcode = grant ? req_opcode[5:3] : req_opcode[2:0];
    sel_a      = grant ? req_a[15:8]     : req_a[7:0];
    sel_b      = grant ? req_b[15:8]     : req_b[7:0];
  end

  // Next-state and handshake outputs; ready is held low while in reset.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    accept    = 1'b0;
    rsp_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && req_valid[grant]) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_nxt        = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_hs    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command, response and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= 3'd0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      rsp_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_flags  <= 8'h00;
      prio       <= 1'b0;
      ops_cnt    <= 16'h0000;
    end else begin
      if (accept) begin
        alu_opcode <= sel_opcode;
        alu_a      <= sel_a;
        alu_b      <= sel_b;
        rsp_id     <= grant;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_salida;
        rsp_flags <= alu_flags;
        rsp_valid <= 1'b1;
      end
      if (rsp_hs) begin
        rsp_valid <= 1'b0;
        prio      <= ~rsp_id;
        ops_cnt   <= ops_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a small behavioural ALU attached
// to the alu_* ports. Expected results below are worked out by hand from
// the ALU behaviour described next to the model.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_opcode;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_data;
  logic [7:0]  rsp_flags;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_salida;
  logic [7:0]  alu_flags;
  logic [15:0] ops_done;

  int checks;
  int fails;
  logic [15:0] exp_cnt;

  typedef struct {
    logic [1:0] valid;
    logic [2:0] op0;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [2:0] op1;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       id;
    logic [7:0] data;
    logic [7:0] flags;
  } vec_t;

  vec_t vecs[9];

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_flags  (rsp_flags),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_salida (alu_salida),
    .alu_flags  (alu_flags),
    .ops_done   (ops_done)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: 0 and, 1 or, 2 add, 3 sub, 4 shl, 5 xor, 6 not A,
  // 7 raw (salida = B, flags = A). Flags N Z C V G Q O P (bit 7..0),
  // C = carry/borrow, G = A>B, Q = A==B, V/O/P zero except in raw mode.
  logic carry;
  always_comb begin
    alu_salida = 8'h00;
    alu_flags  = 8'h00;
    carry      = 1'b0;
    case (alu_opcode)
      3'd0: alu_salida = alu_a & alu_b;
      3'd1: alu_salida = alu_a | alu_b;
      3'd2: {carry, alu_salida} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd3: begin
        alu_salida = alu_a - alu_b;
        carry      = (alu_a < alu_b);
      end
      3'd4: alu_salida = alu_a << alu_b[2:0];
      3'd5: alu_salida = alu_a ^ alu_b;
      3'd6: alu_salida = ~alu_a;
      default: alu_salida = alu_b;
    endcase
    if (alu_opcode == 3'd7) begin
      alu_flags = alu_a;
    end else begin
      alu_flags = {alu_salida[7], (alu_salida == 8'h00), carry, 1'b0,
                   (alu_a > alu_b), (alu_a == alu_b), 2'b00};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"},  {30'd0, req_ready},  32'h0);
    check({tag, ".rsp_valid"},  {31'd0, rsp_valid},  32'h0);
    check({tag, ".rsp_id"},     {31'd0, rsp_id},     32'h0);
    check({tag, ".rsp_data"},   {24'd0, rsp_data},   32'h0);
    check({tag, ".rsp_flags"},  {24'd0, rsp_flags},  32'h0);
    check({tag, ".alu_opcode"}, {29'd0, alu_opcode}, 32'h0);
    check({tag, ".alu_a"},      {24'd0, alu_a},      32'h0);
    check({tag, ".alu_b"},      {24'd0, alu_b},      32'h0);
    check({tag, ".ops_done"},   {16'd0, ops_done},   32'h0);
  endtask

  // One full operation with rsp_ready held high. Called and returns at a
  // falling edge; the accept happens on the next rising edge.
  task automatic do_op(input vec_t v, input string tag);
    logic [1:0] exp_rdy;
    logic [2:0] eop;
    logic [7:0] ea;
    logic [7:0] eb;
    exp_rdy = v.id ? 2'b10 : 2'b01;
    eop     = v.id ? v.op1 : v.op0;
    ea      = v.id ? v.a1  : v.a0;
    eb      = v.id ? v.b1  : v.b0;
    req_valid  = v.valid;
    req_opcode = {v.op1, v.op0};
    req_a      = {v.a1, v.a0};
    req_b      = {v.b1, v.b0};
    rsp_ready  = 1'b1;
    #1;
    check({tag, ".req_ready"}, {30'd0, req_ready}, {30'd0, exp_rdy});
    @(posedge clk);
    @(negedge clk);
    check({tag, ".exec_rsp_valid"}, {31'd0, rsp_valid}, 32'h0);
    check({tag, ".exec_req_ready"}, {30'd0, req_ready}, 32'h0);
    check({tag, ".alu_opcode"}, {29'd0, alu_opcode}, {29'd0, eop});
    check({tag, ".alu_a"}, {24'd0, alu_a}, {24'd0, ea});
    check({tag, ".alu_b"}, {24'd0, alu_b}, {24'd0, eb});
    @(negedge clk);
    check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'h1);
    check({tag, ".rsp_id"}, {31'd0, rsp_id}, {31'd0, v.id});
    check({tag, ".rsp_data"}, {24'd0, rsp_data}, {24'd0, v.data});
    check({tag, ".rsp_flags"}, {24'd0, rsp_flags}, {24'd0, v.flags});
    check({tag, ".resp_req_ready"}, {30'd0, req_ready}, 32'h0);
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    check({tag, ".done_rsp_valid"}, {31'd0, rsp_valid}, 32'h0);
    check({tag, ".ops_done"}, {16'd0, ops_done}, {16'd0, exp_cnt});
  endtask

  vec_t hv;
  logic [7:0] held_data;
  logic [7:0] held_flags;

  initial begin
    checks = 0;
    fails  = 0;
    exp_cnt = 16'h0000;

    // valid  op0  a0     b0     op1  a1     b1     id    data   flags
    vecs[0] = '{2'b11, 3'd2, 8'h05, 8'h03, 3'd3, 8'h03, 8'h03, 1'b0, 8'h08, 8'h08};
    vecs[1] = '{2'b11, 3'd0, 8'hF0, 8'h3C, 3'd3, 8'h03, 8'h03, 1'b1, 8'h00, 8'h44};
    vecs[2] = '{2'b11, 3'd1, 8'hF0, 8'h0F, 3'd3, 8'h03, 8'h03, 1'b0, 8'hFF, 8'h88};
    vecs[3] = '{2'b11, 3'd1, 8'hF0, 8'h0F, 3'd7, 8'h10, 8'h5A, 1'b1, 8'h5A, 8'h10};
    vecs[4] = '{2'b10, 3'd0, 8'h00, 8'h00, 3'd4, 8'h01, 8'h00, 1'b1, 8'h01, 8'h08};
    vecs[5] = '{2'b10, 3'd0, 8'h00, 8'h00, 3'd4, 8'h01, 8'h01, 1'b1, 8'h02, 8'h04};
    vecs[6] = '{2'b10, 3'd0, 8'h00, 8'h00, 3'd4, 8'h01, 8'h02, 1'b1, 8'h04, 8'h00};
    vecs[7] = '{2'b01, 3'd3, 8'h02, 8'h05, 3'd0, 8'h00, 8'h00, 1'b0, 8'hFD, 8'hA0};
    vecs[8] = '{2'b11, 3'd5, 8'hAA, 8'h55, 3'd6, 8'h0F, 8'h00, 1'b1, 8'hF0, 8'h88};

    // Reset with both requesters valid: nothing may be accepted.
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_opcode = 6'o77;
    req_a      = 16'hA5A5;
    req_b      = 16'h5A5A;
    rsp_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    req_valid = 2'b00;
    rst_n     = 1'b1;

    // Table: add, fairness 0,1,0,1, V pass-through, req1 repeated, borrow.
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: hold rsp_ready low for 5 cycles in RESP.
    hv = '{2'b01, 3'd2, 8'h30, 8'h20, 3'd0, 8'h00, 8'h00, 1'b0, 8'h50, 8'h08};
    req_valid  = hv.valid;
    req_opcode = {hv.op1, hv.op0};
    req_a      = {hv.a1, hv.a0};
    req_b      = {hv.b1, hv.b0};
    rsp_ready  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 2'b11;
    req_opcode = 6'o55;
    req_a      = 16'h7777;
    req_b      = 16'h1111;
    @(negedge clk);
    held_data  = 8'h50;
    held_flags = 8'h08;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d.rsp_valid", c), {31'd0, rsp_valid}, 32'h1);
      check($sformatf("bp%0d.rsp_id", c), {31'd0, rsp_id}, 32'h0);
      check($sformatf("bp%0d.rsp_data", c), {24'd0, rsp_data}, {24'd0, held_data});
      check($sformatf("bp%0d.rsp_flags", c), {24'd0, rsp_flags}, {24'd0, held_flags});
      check($sformatf("bp%0d.req_ready", c), {30'd0, req_ready}, 32'h0);
      check($sformatf("bp%0d.alu_a", c), {24'd0, alu_a}, 32'h30);
      check($sformatf("bp%0d.alu_b", c), {24'd0, alu_b}, 32'h20);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    check("bp.done_rsp_valid", {31'd0, rsp_valid}, 32'h0);
    check("bp.ops_done", {16'd0, ops_done}, {16'd0, exp_cnt});
    // Back in IDLE; prio moved to requester 1 after requester 0's response.
    #1;
    check("bp.idle_req_ready", {30'd0, req_ready}, 32'h2);
    req_valid = 2'b00;
    @(negedge clk);

    // Reset in the middle of EXEC discards the operation.
    req_valid  = 2'b01;
    req_opcode = 6'o02;
    req_a      = 16'h0011;
    req_b      = 16'h0022;
    @(posedge clk);
    @(negedge clk);
    check("rx.accepted_alu_a", {24'd0, alu_a}, 32'h11);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rx");
    exp_cnt   = 16'h0000;
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rx%0d.no_rsp", c), {31'd0, rsp_valid}, 32'h0);
    end
    check("rx.ops_done", {16'd0, ops_done}, 32'h0);

    // Counter wrap: preload the completed-operation count near the top.
    dut.ops_cnt = 16'hFFFE;
    exp_cnt     = 16'hFFFE;
    hv = '{2'b01, 3'd0, 8'hFF, 8'h0F, 3'd0, 8'h00, 8'h00, 1'b0, 8'h0F, 8'h08};
    do_op(hv, "wrap_ffff");
    check("wrap.at_ffff", {16'd0, ops_done}, 32'hFFFF);
    hv = '{2'b10, 3'd0, 8'h00, 8'h00, 3'd1, 8'h00, 8'h00, 1'b1, 8'h00, 8'h44};
    do_op(hv, "wrap_zero");
    check("wrap.at_zero", {16'd0, ops_done}, 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
